led_count_allocator: RTL and testbench
======================================

// Module: led_count_allocator
// PURPOSE
//  Upstream stage of the LED driver: converts BIN_QTY note amplitudes (W.D fixed point) into per-bin
//  LED counts proportional to amplitude share, totalling exactly LEDS when any amplitude is nonzero.
//  Runs a multi-cycle sum / divide / remainder-fill sequence; presents LEDCounts with a data_v pulse
//  for the LED driver's start input.
// PARAMETERS
//  LEDS     50  LEDs in strip; must not be a power of two (count LEDS must fit in $clog2(LEDS) bits)
//  BIN_QTY  12  number of note bins
//  W        6   integer bits of amplitude
//  D        10  fractional bits of amplitude
//  AMP_FLOOR 102 amplitude threshold (used only with LCA_AMP_FLOOR_EN)
// PORTS
//  clk             in   1                       clock
//  rst             in   1                       synchronous reset, active-low (rst==0 resets)
//  start           in   1                       request new allocation; accepted only in IDLE
//  noteAmplitudes  in   [BIN_QTY][W+D]          unsigned amplitudes, sampled on accepting edge
//  LEDCounts       out  [BIN_QTY][$clog2(LEDS)] per-bin LED counts, held between results
//  data_v          out  1                       one-cycle pulse: LEDCounts newly valid
//  busy            out  1                       high in every state except IDLE
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, LEDCounts=0, data_v=0, busy=0, internal regs cleared.
//    Reset mid-operation aborts immediately; no data_v is produced for the aborted request.
//  - CW=$clog2(LEDS); sum width W+D+$clog2(BIN_QTY); numerator amp*LEDS width W+D+$clog2(LEDS+1).
//  - States: IDLE, SUM, DIV, FILL, OUT.
//    IDLE: start=1 -> latch amplitudes, clear sum/totals, -> SUM. start ignored in all other states.
//    SUM : one bin per cycle, sum += amp[i]; exactly BIN_QTY cycles. Then sum==0 -> OUT (all
//          counts 0), else -> DIV.
//    DIV : per bin, 1 load cycle + CW restoring-division cycles: q=floor(amp[i]*LEDS/sum), q<=LEDS.
//          Write q into LEDCounts working copy; accumulate total. BIN_QTY*(CW+1) cycles.
//    FILL: leftover=LEDS-total (always < count of nonzero bins). Scan bins 0..BIN_QTY-1, one per
//          cycle; if amp[i]!=0 and leftover>0: count[i]+=1, leftover-=1. Exactly BIN_QTY cycles.
//    OUT : LEDCounts output register <= working copy; data_v=1 for this cycle only; -> IDLE.
//  - Latency: accept edge = cycle 0; data_v high in cycle 2*BIN_QTY+BIN_QTY*(CW+1)+1 (109 at
//    defaults); zero-sum case: cycle BIN_QTY+1 (13). Fixed, data-independent otherwise.
//  - LEDCounts output changes only in OUT; stable while busy. Working copy is internal.
//  - start held high continuously: new request accepted in the IDLE cycle after OUT.
//  - Bins with amp==0 always receive 0. Total==LEDS exactly whenever sum!=0.
// CONFIGURATION
//  LCA_AMP_FLOOR_EN defined: amplitudes < AMP_FLOOR are replaced by 0 when latched (they count
//    as zero in sum, division and FILL eligibility). Timing unchanged.
//  LCA_AMP_FLOOR_EN undefined: amplitudes used as given; AMP_FLOOR unused.
// TESTING
//  1 all amps 0, start -> data_v at cycle 13, all LEDCounts 0, busy low next cycle.
//  2 amp[0]=1024, others 0 -> data_v at cycle 109, LEDCounts[0]=50, all others 0.
//  3 amp[0..2]=1024 -> floors 16,16,16, FILL -> LEDCounts 17,17,16, rest 0; sum of counts 50.
//  4 amp[0]=3072, amp[1]=1024 -> floors 37,12, FILL -> 38,12; start pulsed during DIV ignored,
//    exactly one data_v.
//  5 rst=0 held 1 cycle mid-DIV -> no data_v, LEDCounts 0, busy 0; next start completes normally.
//  6 amp[0]=1024, amp[1]=100: without macro -> 46,4; with LCA_AMP_FLOOR_EN (AMP_FLOOR=102) -> 50,0.

Source files
------------

// File: rtl/led_count_allocator.sv
`default_nettype none
// ============================================================================
// led_count_allocator : splits LEDS LEDs across BIN_QTY bins by amplitude share
// Optional amplitude floor enabled with macro LCA_AMP_FLOOR_EN.   Rev 1.0
// ============================================================================
module led_count_allocator #(
    parameter int LEDS      = 50,
    parameter int BIN_QTY   = 12,
    parameter int W         = 6,
    parameter int D         = 10,
    parameter int AMP_FLOOR = 102
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [BIN_QTY-1:0][W+D-1:0]            noteAmplitudes,
    output logic [BIN_QTY-1:0][$clog2(LEDS)-1:0]   LEDCounts,
    output logic                                   data_v,
    output logic                                   busy
);

    localparam int CW = $clog2(LEDS);
    localparam int AW = W + D;
    localparam int SW = AW + $clog2(BIN_QTY);
    localparam int NW = AW + $clog2(LEDS + 1);
    localparam int DW = (SW + CW > NW) ? SW + CW : NW;
    localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
    localparam int KW = $clog2(CW + 1);
    localparam logic [BW-1:0] LAST_BIN = BW'(BIN_QTY - 1);
    localparam logic [KW-1:0] LAST_STEP = KW'(CW);
`ifdef LCA_AMP_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUM  = 3'd1,
        S_DIV  = 3'd2,
        S_FILL = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t state, next_state;

    logic [BIN_QTY-1:0][AW-1:0] amp;
    logic [BIN_QTY-1:0][CW-1:0] work;
    logic [SW-1:0]              sum;
    logic [CW:0]                total;
    logic [CW:0]                leftover;
    logic [BW-1:0]              bin;
    logic [KW-1:0]              step;
    logic [DW-1:0]              num;
    logic [CW-1:0]              quo;

    logic [BIN_QTY-1:0][AW-1:0] amp_in;
    logic [AW-1:0]              cur_amp;
    logic [SW-1:0]              sum_next;
    logic [DW-1:0]              div_sh;
    logic                       div_ge;
    logic [DW-1:0]              num_next;
    logic [CW-1:0]              quo_next;
    logic                       fill_inc;
    logic [CW-1:0]              fill_cnt;

    always_comb begin
        for (int i = 0; i < BIN_QTY; i++) begin
            amp_in[i] = noteAmplitudes[i];
            if (FLOOR_EN && (noteAmplitudes[i] < AW'(AMP_FLOOR)))
                amp_in[i] = '0;
        end
    end

    // Restoring division with a pre-shifted divisor: quotient bits come out MSB first.
    assign cur_amp  = amp[bin];
    assign sum_next = sum + SW'(cur_amp);
    assign div_sh   = DW'(sum) << (LAST_STEP - step);
    assign div_ge   = (num >= div_sh);
    assign num_next = div_ge ? (num - div_sh) : num;
    assign quo_next = (quo << 1) | CW'(div_ge);
    assign fill_inc = (cur_amp != '0) && (leftover != '0);
    assign fill_cnt = work[bin] + CW'(fill_inc);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        data_v     = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) next_state = S_SUM;
            end
            S_SUM:
                if (bin == LAST_BIN) next_state = (sum_next == '0) ? S_OUT : S_DIV;
            S_DIV:
                if (step == LAST_STEP && bin == LAST_BIN) next_state = S_FILL;
            S_FILL:
                if (bin == LAST_BIN) next_state = S_OUT;
            S_OUT: begin
                data_v     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // LEDCounts is loaded on the edge entering OUT so it is valid alongside data_v.
    always_ff @(posedge clk) begin
        if (!rst) begin
            amp       <= '0;
            work      <= '0;
            sum       <= '0;
            total     <= '0;
            leftover  <= '0;
            bin       <= '0;
            step      <= '0;
            num       <= '0;
            quo       <= '0;
            LEDCounts <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        amp   <= amp_in;
                        work  <= '0;
                        sum   <= '0;
                        total <= '0;
                        bin   <= '0;
                        step  <= '0;
                    end
                end
                S_SUM: begin
                    sum  <= sum_next;
                    step <= '0;
                    if (bin == LAST_BIN) begin
                        bin <= '0;
                        if (sum_next == '0) LEDCounts <= work;
                    end else begin
                        bin <= bin + 1'b1;
                    end
                end
                S_DIV: begin
                    if (step == '0) begin
                        num  <= DW'(cur_amp) * DW'(LEDS);
                        quo  <= '0;
                        step <= step + 1'b1;
                    end else begin
                        num <= num_next;
                        quo <= quo_next;
                        if (step == LAST_STEP) begin
                            work[bin] <= quo_next;
                            total     <= total + (CW+1)'(quo_next);
                            step      <= '0;
                            if (bin == LAST_BIN) begin
                                bin      <= '0;
                                leftover <= (CW+1)'(LEDS) - total - (CW+1)'(quo_next);
                            end else begin
                                bin <= bin + 1'b1;
                            end
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (fill_inc) begin
                        work[bin] <= fill_cnt;
                        leftover  <= leftover - 1'b1;
                    end
                    if (bin == LAST_BIN) begin
                        bin                 <= '0;
                        LEDCounts           <= work;
                        LEDCounts[LAST_BIN] <= fill_cnt;
                    end else begin
                        bin <= bin + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_count_allocator.sv
`default_nettype none
// Bench for led_count_allocator: directed cases plus random amplitudes vs. a share model.
module tb_led_count_allocator;

    localparam int LEDS      = 50;
    localparam int BIN_QTY   = 12;
    localparam int W         = 6;
    localparam int D         = 10;
    localparam int AMP_FLOOR = 102;
    localparam int CW        = $clog2(LEDS);
    localparam int AW        = W + D;
    localparam int LAT_FULL  = 2*BIN_QTY + BIN_QTY*(CW+1) + 1;
    localparam int LAT_ZERO  = BIN_QTY + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [BIN_QTY-1:0][AW-1:0] amps = '0;
    logic [BIN_QTY-1:0][CW-1:0] counts;
    logic data_v;
    logic busy;

    int checks = 0;
    int errors = 0;
    int exp_cnt[BIN_QTY];
    int prev_exp[BIN_QTY];
    bit exp_zero;

    led_count_allocator #(
        .LEDS(LEDS), .BIN_QTY(BIN_QTY), .W(W), .D(D), .AMP_FLOOR(AMP_FLOOR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .noteAmplitudes(amps),
        .LEDCounts(counts), .data_v(data_v), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Proportional share: floor of each share, then leftovers to the earliest nonzero bins.
    function automatic void model();
        longint a[BIN_QTY];
        longint s = 0;
        int tot = 0;
        int left;
        for (int i = 0; i < BIN_QTY; i++) begin
            a[i] = longint'(amps[i]);
`ifdef LCA_AMP_FLOOR_EN
            if (a[i] < AMP_FLOOR) a[i] = 0;
`endif
            s += a[i];
        end
        for (int i = 0; i < BIN_QTY; i++) begin
            exp_cnt[i] = (s == 0) ? 0 : int'((a[i] * LEDS) / s);
            tot += exp_cnt[i];
        end
        left = (s == 0) ? 0 : LEDS - tot;
        for (int i = 0; i < BIN_QTY; i++)
            if (a[i] != 0 && left > 0) begin
                exp_cnt[i]++;
                left--;
            end
        exp_zero = (s == 0);
    endfunction

    task automatic check_counts(input string tag);
        int total = 0;
        for (int i = 0; i < BIN_QTY; i++) begin
            check($sformatf("%s_cnt%0d", tag, i), 64'(counts[i]), 64'(exp_cnt[i]));
            total += int'(counts[i]);
        end
        check({tag, "_total"}, 64'(total), exp_zero ? 64'd0 : 64'(LEDS));
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One allocation; optionally pulses start at cycle 'poke' to show it is ignored.
    task automatic run(input string tag, input int poke);
        int cyc;
        int pulses;
        int lat;
        bit unstable;
        model();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1; pulses = 0; lat = -1; unstable = 1'b0;
        while (cyc <= LAT_FULL + 4) begin
            if (data_v === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc;
                    check_counts(tag);
                end
            end else if (lat < 0) begin
                for (int i = 0; i < BIN_QTY; i++)
                    if (counts[i] !== CW'(prev_exp[i])) unstable = 1'b1;
            end
            start = (cyc == poke);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), exp_zero ? 64'(LAT_ZERO) : 64'(LAT_FULL));
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_stable"}, 64'(unstable), 64'd0);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        for (int i = 0; i < BIN_QTY; i++) prev_exp[i] = exp_cnt[i];
    endtask

    initial begin
        int lat1;
        int lat2;
        int cyc;
        int pulses;

        for (int i = 0; i < BIN_QTY; i++) prev_exp[i] = 0;
        wait_cycles(3);
        check("reset_data_v", 64'(data_v), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_counts", 64'(counts), 64'd0);
        rst = 1'b1;
        wait_cycles(2);

        amps = '0;
        run("zero", 0);

        amps = '0; amps[0] = 16'd1024;
        run("single", 0);

        amps = '0; amps[0] = 16'd1024; amps[1] = 16'd1024; amps[2] = 16'd1024;
        run("three", 0);

        amps = '0; amps[0] = 16'd3072; amps[1] = 16'd1024;
        run("poke_div", 30);

        // Reset in the middle of DIV aborts the request.
        amps = '0; amps[3] = 16'd500; amps[7] = 16'd2000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cycles(40);
        rst = 1'b0;
        wait_cycles(1);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < LAT_FULL + 10; i++) begin
            if (data_v === 1'b1) pulses++;
            wait_cycles(1);
        end
        check("abort_pulses", 64'(pulses), 64'd0);
        check("abort_counts", 64'(counts), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < BIN_QTY; i++) prev_exp[i] = 0;
        run("after_abort", 0);

        amps = '0; amps[0] = 16'd1024; amps[1] = 16'd100;
        run("floor_case", 0);

        // Continuous start: back-to-back requests one IDLE cycle apart.
        amps = '0; amps[2] = 16'd777; amps[5] = 16'd333; amps[11] = 16'd4096;
        model();
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1; lat1 = -1; lat2 = -1;
        while (cyc <= 2*LAT_FULL + 10 && lat2 < 0) begin
            if (data_v === 1'b1) begin
                if (lat1 < 0) lat1 = cyc;
                else          lat2 = cyc;
            end
            wait_cycles(1);
            cyc++;
        end
        start = 1'b0;
        check("held_first", 64'(lat1), 64'(LAT_FULL));
        check("held_interval", 64'(lat2 - lat1), 64'(LAT_FULL + 1));
        check_counts("held");
        wait_cycles(LAT_FULL + 4);
        check("held_idle", 64'(busy), 64'd0);
        for (int i = 0; i < BIN_QTY; i++) prev_exp[i] = exp_cnt[i];

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < BIN_QTY; i++) begin
                case ($urandom_range(0, 3))
                    0:       amps[i] = '0;
                    1:       amps[i] = AW'($urandom_range(0, 200));
                    default: amps[i] = AW'($urandom_range(0, 65535));
                endcase
            end
            run($sformatf("rand%0d", n), (n % 2 == 0) ? 0 : int'($urandom_range(2, 90)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
